// File: rtl/tree_pkg.sv
// Shared types and constants for the tree image loader.
package tree_pkg;

  localparam int unsigned TREE_IDX_W = 6;
  localparam logic [7:0]  LOAD_HDR   = 8'hA5;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_BUY    = 2'd1,
    ACT_SELL   = 2'd2,
    ACT_CANCEL = 2'd3
  } action_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_COUNT = 2'd1,
    ERR_BAD_INDEX = 2'd2,
    ERR_BAD_CSUM  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CSUM
  } load_state_e;

  // One node record as written into node memory; child indices kept at full byte-packing width.
  typedef struct packed {
    logic                  is_leaf;
    logic [7:0]            threshold;
    logic                  less_than;
    logic [TREE_IDX_W-1:0] left;
    logic [TREE_IDX_W-1:0] right;
    action_e               action;
  } node_t;

endpackage

// File: rtl/tree_stream_loader_if.sv
// Valid/ready byte stream feeding the tree loader.
interface tree_stream_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tree_stream_loader.sv
// Framed byte-stream loader for decision-tree node memory: unpacks node records,
// writes them at sequential addresses, validates count, child indices and checksum.
// ADDR_WIDTH must not exceed 6: child indices share a byte with two flag/action bits.
module tree_stream_loader
  import tree_pkg::*;
#(
  parameter int unsigned MAX_NODES  = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  tree_stream_loader_if.slave   byte_in,
  output logic                  sw_we,
  output logic [ADDR_WIDTH-1:0] sw_addr,
  output logic                  sw_data_is_leaf,
  output logic                  sw_data_less_than,
  output logic [7:0]            sw_data_threshold,
  output logic [ADDR_WIDTH-1:0] sw_data_left_idx,
  output logic [ADDR_WIDTH-1:0] sw_data_right_idx,
  output logic [1:0]            sw_data_action,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   nodes_loaded
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  load_state_e            state_q, state_d;
  logic                   in_ready_q;
  logic                   accept;
  logic                   hdr_seen, wr_start, done_set, err_set;
  err_code_e              err_kind;
  logic [CNT_W-1:0]       count_q;
  logic [7:0]             csum_q;
  logic [7:0]             thr_q;
  logic                   leaf_q, lt_q;
  logic [TREE_IDX_W-1:0]  left_q;
  logic [CNT_W-1:0]       left_ext, right_ext;
  node_t                  wr_node_q;

  assign accept           = in_ready_q & byte_in.in_valid;
  assign byte_in.in_ready = in_ready_q;
  assign left_ext         = CNT_W'(left_q[ADDR_WIDTH-1:0]);
  assign right_ext        = CNT_W'(byte_in.in_data[ADDR_WIDTH-1:0]);

  assign sw_data_is_leaf   = wr_node_q.is_leaf;
  assign sw_data_less_than = wr_node_q.less_than;
  assign sw_data_threshold = wr_node_q.threshold;
  assign sw_data_left_idx  = wr_node_q.left[ADDR_WIDTH-1:0];
  assign sw_data_right_idx = wr_node_q.right[ADDR_WIDTH-1:0];
  assign sw_data_action    = wr_node_q.action;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    hdr_seen = 1'b0;
    wr_start = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    err_kind = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept && byte_in.in_data == LOAD_HDR) begin
          hdr_seen = 1'b1;
          state_d  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (accept) begin
          if (byte_in.in_data == 8'd0 || byte_in.in_data > 8'(MAX_NODES)) begin
            err_set  = 1'b1;
            err_kind = ERR_BAD_COUNT;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_B0;
          end
        end
      end
      ST_B0: if (accept) state_d = ST_B1;
      ST_B1: if (accept) state_d = ST_B2;
      ST_B2: begin
        if (accept) begin
          if (!leaf_q && (left_ext >= count_q || right_ext >= count_q)) begin
            err_set  = 1'b1;
            err_kind = ERR_BAD_INDEX;
            state_d  = ST_IDLE;
          end else begin
            wr_start = 1'b1;
            state_d  = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = (nodes_loaded + CNT_W'(1) < count_q) ? ST_B0 : ST_CSUM;
      ST_CSUM: begin
        if (accept) begin
          if (byte_in.in_data == csum_q) begin
            done_set = 1'b1;
          end else begin
            err_set  = 1'b1;
            err_kind = ERR_BAD_CSUM;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: byte capture, checksum, node counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b1;
      load_busy    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      err_code     <= 2'd0;
      nodes_loaded <= '0;
      sw_we        <= 1'b0;
      sw_addr      <= '0;
      wr_node_q    <= '0;
      count_q      <= '0;
      csum_q       <= 8'd0;
      thr_q        <= 8'd0;
      leaf_q       <= 1'b0;
      lt_q         <= 1'b0;
      left_q       <= '0;
    end else begin
      in_ready_q <= (state_d != ST_WRITE);
      load_busy  <= (state_d != ST_IDLE);
      sw_we      <= wr_start;
      load_done  <= done_set;
      load_err   <= err_set;
      if (err_set) err_code <= err_kind;
      if (hdr_seen) begin
        nodes_loaded <= '0;
        csum_q       <= 8'd0;
      end
      if (accept) begin
        case (state_q)
          ST_COUNT: begin
            count_q <= CNT_W'(byte_in.in_data);
            csum_q  <= byte_in.in_data;
          end
          ST_B0: begin
            thr_q  <= byte_in.in_data;
            csum_q <= csum_q ^ byte_in.in_data;
          end
          ST_B1: begin
            leaf_q <= byte_in.in_data[7];
            lt_q   <= byte_in.in_data[6];
            left_q <= byte_in.in_data[TREE_IDX_W-1:0];
            csum_q <= csum_q ^ byte_in.in_data;
          end
          ST_B2:   csum_q <= csum_q ^ byte_in.in_data;
          default: ;
        endcase
      end
      // Write fields change only when a write starts, so they stay stable while sw_we is low.
      if (wr_start) begin
        sw_addr   <= nodes_loaded[ADDR_WIDTH-1:0];
        wr_node_q <= '{is_leaf:   leaf_q,
                       threshold: thr_q,
                       less_than: lt_q,
                       left:      left_q,
                       right:     byte_in.in_data[TREE_IDX_W-1:0],
                       action:    action_e'(byte_in.in_data[7:6])};
      end
      if (state_q == ST_WRITE) nodes_loaded <= nodes_loaded + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tree_stream_loader.sv
// Randomized self-checking bench for tree_stream_loader against a frame-level reference model.
module tb_tree_stream_loader;
  import tree_pkg::*;

  localparam int unsigned MAX_NODES = 64;
  localparam int unsigned AW        = 6;

  typedef logic [7:0]  bq_t[$];
  typedef logic [29:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tree_stream_loader_if sif();

  logic          sw_we;
  logic [AW-1:0] sw_addr;
  logic          sw_data_is_leaf, sw_data_less_than;
  logic [7:0]    sw_data_threshold;
  logic [AW-1:0] sw_data_left_idx, sw_data_right_idx;
  logic [1:0]    sw_data_action;
  logic          load_busy, load_done, load_err;
  logic [1:0]    err_code;
  logic [AW:0]   nodes_loaded;

  tree_stream_loader #(.MAX_NODES(MAX_NODES), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .byte_in           (sif),
    .sw_we             (sw_we),
    .sw_addr           (sw_addr),
    .sw_data_is_leaf   (sw_data_is_leaf),
    .sw_data_less_than (sw_data_less_than),
    .sw_data_threshold (sw_data_threshold),
    .sw_data_left_idx  (sw_data_left_idx),
    .sw_data_right_idx (sw_data_right_idx),
    .sw_data_action    (sw_data_action),
    .load_busy         (load_busy),
    .load_done         (load_done),
    .load_err          (load_err),
    .err_code          (err_code),
    .nodes_loaded      (nodes_loaded)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write record layout: {addr, is_leaf, less_than, threshold, left, right, action}.
  function automatic logic [29:0] wpack(input logic [5:0] a, input logic lf, input logic lt,
                                        input logic [7:0] th, input logic [5:0] l,
                                        input logic [5:0] r, input logic [1:0] act);
    return {a, lf, lt, th, l, r, act};
  endfunction

  logic [29:0] cur;
  assign cur = wpack(sw_addr, sw_data_is_leaf, sw_data_less_than, sw_data_threshold,
                     sw_data_left_idx, sw_data_right_idx, sw_data_action);

  wq_t         got_w;
  int          got_ev[$];
  int          hs_cyc[$];
  int          cyc = 0;
  logic [29:0] hold = '0;
  bit          gaps = 1'b0;

  // Handshake timestamps for frame-timing checks.
  always @(posedge clk) begin
    cyc++;
    if (!rst && sif.in_valid && sif.in_ready) hs_cyc.push_back(cyc);
  end

  // Output monitor: captures writes and outcome pulses, checks per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      hold = '0;
    end else begin
      check_eq("ready_vs_we", 32'(sif.in_ready), 32'(!sw_we));
      if (sw_we) begin
        got_w.push_back(cur);
        hold = cur;
      end else begin
        check_eq("sw_hold", 32'(cur), 32'(hold));
      end
      if (load_done) got_ev.push_back(0);
      if (load_err)  got_ev.push_back(int'(err_code));
      if (load_done || load_err) check_eq("busy_at_pulse", 32'(load_busy), 32'd0);
    end
  end

  // Reference model: walks a byte stream frame by frame from the framing rules.
  // ev: 0 = done, 1..3 = error code.
  task automatic model(input bq_t b, output wq_t w, output int ev, output int nl);
    wq_t        lw;
    int         i = 0;
    int         n;
    logic [7:0] cs, b0, b1, b2;
    while (i < b.size() && b[i] != 8'hA5) i++;
    i++;
    n = int'(b[i]);
    i++;
    if (n == 0 || n > MAX_NODES) begin
      ev = 1; nl = 0; w = lw;
      return;
    end
    cs = b[i-1];
    for (int k = 0; k < n; k++) begin
      b0 = b[i]; b1 = b[i+1]; b2 = b[i+2];
      i += 3;
      cs = cs ^ b0 ^ b1 ^ b2;
      if (!b1[7] && (int'(b1[5:0]) >= n || int'(b2[5:0]) >= n)) begin
        ev = 2; nl = k; w = lw;
        return;
      end
      lw.push_back(wpack(6'(k), b1[7], b1[6], b0, b1[5:0], b2[5:0], b2[7:6]));
    end
    nl = n;
    ev = (b[i] == cs) ? 0 : 3;
    w  = lw;
  endtask

  // Drives one byte, optionally after a random idle gap; returns at the negedge after the handshake.
  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      sif.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    sif.in_data  = d;
    sif.in_valid = 1'b1;
    while (!sif.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready_wait", 32'(t < 20), 32'd1);
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input bq_t b, input int timing_n);
    wq_t exp_w;
    int  exp_ev, exp_nl, span;
    model(b, exp_w, exp_ev, exp_nl);
    got_w.delete();
    got_ev.delete();
    hs_cyc.delete();
    foreach (b[i]) send_byte(b[i]);
    repeat (4) @(negedge clk);
    check_eq({name, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check_eq({name, "_write"}, 32'(got_w[i]), 32'(exp_w[i]));
    check_eq({name, "_nevents"}, 32'(got_ev.size()), 32'd1);
    if (got_ev.size() > 0) check_eq({name, "_outcome"}, 32'(got_ev[0]), 32'(exp_ev));
    check_eq({name, "_nodes_loaded"}, 32'(nodes_loaded), 32'(exp_nl));
    check_eq({name, "_busy_after"}, 32'(load_busy), 32'd0);
    if (timing_n >= 0) begin
      span = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] + 1 : 0;
      check_eq({name, "_frame_cycles"}, 32'(span), 32'(4 * timing_n + 3));
    end
  endtask

  // Random frame generator. kind: 0 good, 1 bad checksum, 2 bad index, 3 bad count.
  task automatic gen_frame(input int kind, output bq_t q);
    bq_t        lq;
    int         n, bad, l, r;
    logic [7:0] g, cs, b0, b1, b2;
    logic       lf;
    repeat ($urandom_range(0, 2)) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h00;
      lq.push_back(g);
    end
    lq.push_back(8'hA5);
    if (kind == 3) begin
      lq.push_back(($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(65, 255)));
      q = lq;
      return;
    end
    n = $urandom_range(1, 12);
    lq.push_back(8'(n));
    cs  = 8'(n);
    bad = (kind == 2) ? $urandom_range(0, n - 1) : -1;
    for (int k = 0; k < n; k++) begin
      lf = ($urandom_range(0, 3) == 0);
      l  = lf ? $urandom_range(0, 63) : $urandom_range(0, n - 1);
      r  = lf ? $urandom_range(0, 63) : $urandom_range(0, n - 1);
      if (k == bad) begin
        lf = 1'b0;
        if ($urandom_range(0, 1) == 1) l = $urandom_range(n, 63);
        else                           r = $urandom_range(n, 63);
      end
      b0 = 8'($urandom_range(0, 255));
      b1 = {lf, 1'($urandom_range(0, 1)), 6'(l)};
      b2 = {2'($urandom_range(0, 3)), 6'(r)};
      lq.push_back(b0); lq.push_back(b1); lq.push_back(b2);
      cs = cs ^ b0 ^ b1 ^ b2;
      if (k == bad) begin
        q = lq;
        return;
      end
    end
    if (kind == 1) cs = cs ^ 8'($urandom_range(1, 255));
    lq.push_back(cs);
    q = lq;
  endtask

  task automatic append_csum(input bq_t f, output bq_t q);
    logic [7:0] cs = 8'd0;
    for (int i = 1; i < f.size(); i++) cs ^= f[i];
    q = f;
    q.push_back(cs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         f, f7;
    logic [29:0] mem [64];
    logic [29:0] e;
    logic [1:0]  act;
    int          node;
    bit          go_left;

    sif.in_data  = 8'h00;
    sif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check_eq("rst_in_ready", 32'(sif.in_ready), 32'd1);
    check_eq("rst_sw_we", 32'(sw_we), 32'd0);
    check_eq("rst_sw_fields", 32'(cur), 32'd0);
    check_eq("rst_busy", 32'(load_busy), 32'd0);
    check_eq("rst_done_err", 32'({load_done, load_err}), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);
    check_eq("rst_nodes", 32'(nodes_loaded), 32'd0);

    f = '{8'hA5, 8'h01, 8'h00, 8'h80, 8'h40, 8'hC1};
    run_frame("good1", f, 1);
    f = '{8'hA5, 8'h00};
    run_frame("count0", f, -1);
    f = '{8'hA5, 8'h41};
    run_frame("count65", f, -1);
    f = '{8'hA5, 8'h01, 8'h0A, 8'h41, 8'h02};
    run_frame("badidx", f, -1);
    f = '{8'hA5, 8'h01, 8'h00, 8'h80, 8'h40, 8'h00};
    run_frame("badcsum", f, -1);

    // Reset after B1 of node 0: nothing written, outputs return to reset values.
    got_w.delete();
    f = '{8'hA5, 8'h01, 8'h00, 8'h80};
    foreach (f[i]) send_byte(f[i]);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_writes", 32'(got_w.size()), 32'd0);
    check_eq("midrst_sw_we", 32'(sw_we), 32'd0);
    check_eq("midrst_in_ready", 32'(sif.in_ready), 32'd1);
    check_eq("midrst_busy", 32'(load_busy), 32'd0);
    check_eq("midrst_err_code", 32'(err_code), 32'd0);
    check_eq("midrst_nodes", 32'(nodes_loaded), 32'd0);
    check_eq("midrst_fields", 32'(cur), 32'd0);
    f = '{8'hA5, 8'h01, 8'h00, 8'h80, 8'h40, 8'hC1};
    run_frame("after_rst", f, 1);

    // 7-node tree: root splits to two compare nodes, four leaves (SELL, BUY, CANCEL, NONE).
    f = '{8'hA5, 8'h07,
          8'h0A, 8'h41, 8'h02,
          8'h03, 8'h43, 8'h04,
          8'h14, 8'h45, 8'h06,
          8'h00, 8'h80, 8'h80,
          8'h00, 8'h80, 8'h40,
          8'h00, 8'h80, 8'hC0,
          8'h00, 8'h80, 8'h00};
    append_csum(f, f7);
    run_frame("tree7_timing", f7, 7);
    f = '{8'h12, 8'h34};
    foreach (f7[i]) f.push_back(f7[i]);
    gaps = 1'b1;
    run_frame("tree7_gaps", f, -1);
    gaps = 1'b0;

    // Downstream walk: go left when (less_than ? x < thr : x >= thr); x = 5 should reach BUY.
    foreach (mem[i]) mem[i] = '0;
    foreach (got_w[i]) mem[got_w[i][29:24]] = got_w[i];
    node = 0;
    act  = 2'd0;
    for (int s = 0; s < 8; s++) begin
      e = mem[node];
      if (e[23]) begin
        act = e[1:0];
        break;
      end
      go_left = e[22] ? (8'd5 < e[21:14]) : (8'd5 >= e[21:14]);
      node    = go_left ? int'(e[13:8]) : int'(e[7:2]);
    end
    check_eq("tree_eval_x5", 32'(act), 32'(ACT_BUY));

    for (int it = 0; it < 30; it++) begin
      gaps = ($urandom_range(0, 1) == 1);
      gen_frame($urandom_range(0, 3), f);
      run_frame("rnd", f, -1);
    end
    gaps = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
